// File: rtl/alu_16_bit_pkg.sv
// Shared types for the 16-bit ALU command sequencer: opcodes, command word,
// sequencer FSM states and the fixed divide-by-zero result.
package alu_16_bit_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int OP_WIDTH   = 4;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_INC    = 4'h0,
    OP_DEC    = 4'h1,
    OP_ADD    = 4'h2,
    OP_SUB_AB = 4'h3,
    OP_SUB_BA = 4'h4,
    OP_MUL    = 4'h5,
    OP_DIV    = 4'h6,
    OP_MOD    = 4'h7,
    OP_AND    = 4'h8,
    OP_OR     = 4'h9,
    OP_NOT_A  = 4'hA,
    OP_NOT_B  = 4'hB,
    OP_NAND   = 4'hC,
    OP_NOR    = 4'hD,
    OP_XOR    = 4'hE,
    OP_XNOR   = 4'hF
  } alu_op_e;

  typedef struct packed {
    alu_op_e               op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRIVE,
    ST_RESPOND
  } seq_state_e;

  localparam logic [DATA_WIDTH-1:0] DIV_ZERO_RESULT = 16'hFFFF;

  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO of alu_cmd_t words with occupancy count and a
// registered empty flag so the consumer's pop decision has no comb path to count.
module alu_cmd_fifo
  import alu_16_bit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  alu_cmd_t             i_push_data,
  input  logic                 i_pop,
  output alu_cmd_t             o_pop_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  alu_cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic                 r_empty;
  logic [PTR_W:0]       w_count_next;
  logic                 w_push_en;
  logic                 w_pop_en;

  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_push_en  = i_push && !o_full;
  assign w_pop_en   = i_pop && !r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push_en && !w_pop_en)
      w_count_next = r_count + (PTR_W+1)'(1);
    else if (!w_push_en && w_pop_en)
      w_count_next = r_count - (PTR_W+1)'(1);
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_push_en)
      r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_en)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_en)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
    end
  end

endmodule

// File: rtl/alu_16_bit_sequencer.sv
// Buffers ALU commands, issues them one at a time to the external ALU, holds
// operands for a settle window and returns results in accept order.
module alu_16_bit_sequencer
  import alu_16_bit_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                      Clock_In,
  input  logic                      Reset_n_In,
  input  logic                      Cmd_Valid_In,
  output logic                      Cmd_Ready_Out,
  input  logic [OP_WIDTH-1:0]       Cmd_Op_In,
  input  logic [DATA_WIDTH-1:0]     Cmd_A_In,
  input  logic [DATA_WIDTH-1:0]     Cmd_B_In,
  output logic [$clog2(FIFO_DEPTH):0] Cmd_Count_Out,
  output logic                      Busy_Out,
  output logic                      ALU_Enable_Out,
  output logic [OP_WIDTH-1:0]       ALU_Operation_Select_Out,
  output logic [DATA_WIDTH-1:0]     ALU_Data_A_Out,
  output logic [DATA_WIDTH-1:0]     ALU_Data_B_Out,
  input  logic [DATA_WIDTH-1:0]     ALU_Result_In,
  input  logic                      ALU_Carry_In,
  output logic                      Rsp_Valid_Out,
  input  logic                      Rsp_Ready_In,
  output logic [DATA_WIDTH-1:0]     Rsp_Result_Out,
  output logic                      Rsp_Carry_Out,
  output logic                      Rsp_Zero_Out,
  output logic                      Rsp_Div_Zero_Out
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  alu_cmd_t              w_push_cmd;
  alu_cmd_t              w_fifo_dout;

  seq_state_e            r_state;
  alu_cmd_t              r_cmd;
  logic [SET_W-1:0]      r_settle;
  logic                  r_alu_en;
  logic [OP_WIDTH-1:0]   r_alu_op;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_carry;
  logic                  r_rsp_zero;
  logic                  r_rsp_div_zero;

  assign w_push_cmd = '{op: alu_op_e'(Cmd_Op_In), a: Cmd_A_In, b: Cmd_B_In};
  assign w_push     = Cmd_Valid_In && !w_fifo_full;
  // Pop only from IDLE or on a completed response handshake.
  assign w_pop      = !w_fifo_empty &&
                      ((r_state == ST_IDLE) || (r_state == ST_RESPOND && Rsp_Ready_In));

  alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .i_clk       (Clock_In),
    .i_rst_n     (Reset_n_In),
    .i_push      (w_push),
    .i_push_data (w_push_cmd),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_dout),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (Cmd_Count_Out)
  );

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      r_state        <= ST_IDLE;
      r_cmd          <= '0;
      r_settle       <= '0;
      r_alu_en       <= 1'b0;
      r_alu_op       <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_carry    <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_cmd   <= w_fifo_dout;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (is_div_op(r_cmd.op) && (r_cmd.b == '0)) begin
            r_rsp_result   <= DIV_ZERO_RESULT;
            r_rsp_carry    <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_div_zero <= 1'b1;
            r_rsp_valid    <= 1'b1;
            r_state        <= ST_RESPOND;
          end else begin
            r_alu_en <= 1'b1;
            r_alu_op <= r_cmd.op;
            r_alu_a  <= r_cmd.a;
            r_alu_b  <= r_cmd.b;
            r_settle <= SET_W'(SETTLE_CYCLES - 1);
            r_state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_settle == '0) begin
            r_rsp_result   <= ALU_Result_In;
            r_rsp_carry    <= ALU_Carry_In;
            r_rsp_zero     <= (ALU_Result_In == '0);
            r_rsp_div_zero <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_alu_en       <= 1'b0;
            r_state        <= ST_RESPOND;
          end else begin
            r_settle <= r_settle - SET_W'(1);
          end
        end
        ST_RESPOND: begin
          if (Rsp_Ready_In) begin
            r_rsp_valid <= 1'b0;
            if (!w_fifo_empty) begin
              r_cmd   <= w_fifo_dout;
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Cmd_Ready_Out            = !w_fifo_full;
  assign Busy_Out                 = (r_state != ST_IDLE) || !w_fifo_empty;
  assign ALU_Enable_Out           = r_alu_en;
  assign ALU_Operation_Select_Out = r_alu_op;
  assign ALU_Data_A_Out           = r_alu_a;
  assign ALU_Data_B_Out           = r_alu_b;
  assign Rsp_Valid_Out            = r_rsp_valid;
  assign Rsp_Result_Out           = r_rsp_result;
  assign Rsp_Carry_Out            = r_rsp_carry;
  assign Rsp_Zero_Out             = r_rsp_zero;
  assign Rsp_Div_Zero_Out         = r_rsp_div_zero;

endmodule

// File: tb/tb_alu_16_bit_sequencer.sv
// Self-checking bench: behavioural ALU beside the sequencer, directed latency
// cases, back-pressure, reset mid-operation and a randomized scoreboard run.
module tb_alu_16_bit_sequencer;

  logic        Clock_In = 1'b0;
  logic        Reset_n_In;
  logic        Cmd_Valid_In;
  logic        Cmd_Ready_Out;
  logic [3:0]  Cmd_Op_In;
  logic [15:0] Cmd_A_In;
  logic [15:0] Cmd_B_In;
  logic [2:0]  Cmd_Count_Out;
  logic        Busy_Out;
  logic        ALU_Enable_Out;
  logic [3:0]  ALU_Operation_Select_Out;
  logic [15:0] ALU_Data_A_Out;
  logic [15:0] ALU_Data_B_Out;
  logic [15:0] ALU_Result_In;
  logic        ALU_Carry_In;
  logic        Rsp_Valid_Out;
  logic        Rsp_Ready_In;
  logic [15:0] Rsp_Result_Out;
  logic        Rsp_Carry_Out;
  logic        Rsp_Zero_Out;
  logic        Rsp_Div_Zero_Out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [18:0] exp_q[$];

  always #5 Clock_In = ~Clock_In;

  alu_16_bit_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .Clock_In                 (Clock_In),
    .Reset_n_In               (Reset_n_In),
    .Cmd_Valid_In             (Cmd_Valid_In),
    .Cmd_Ready_Out            (Cmd_Ready_Out),
    .Cmd_Op_In                (Cmd_Op_In),
    .Cmd_A_In                 (Cmd_A_In),
    .Cmd_B_In                 (Cmd_B_In),
    .Cmd_Count_Out            (Cmd_Count_Out),
    .Busy_Out                 (Busy_Out),
    .ALU_Enable_Out           (ALU_Enable_Out),
    .ALU_Operation_Select_Out (ALU_Operation_Select_Out),
    .ALU_Data_A_Out           (ALU_Data_A_Out),
    .ALU_Data_B_Out           (ALU_Data_B_Out),
    .ALU_Result_In            (ALU_Result_In),
    .ALU_Carry_In             (ALU_Carry_In),
    .Rsp_Valid_Out            (Rsp_Valid_Out),
    .Rsp_Ready_In             (Rsp_Ready_In),
    .Rsp_Result_Out           (Rsp_Result_Out),
    .Rsp_Carry_Out            (Rsp_Carry_Out),
    .Rsp_Zero_Out             (Rsp_Zero_Out),
    .Rsp_Div_Zero_Out         (Rsp_Div_Zero_Out)
  );

  // Arithmetic of the external ALU as {carry, result}.
  function automatic logic [16:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      4'h0: return {1'b0, a} + 17'd1;
      4'h1: return {1'b0, a} - 17'd1;
      4'h2: return {1'b0, a} + {1'b0, b};
      4'h3: return {1'b0, a} - {1'b0, b};
      4'h4: return {1'b0, b} - {1'b0, a};
      4'h5: return p[16:0];
      4'h6: return (b == 0) ? 17'h0FFFF : {1'b0, a / b};
      4'h7: return (b == 0) ? 17'h0FFFF : {1'b0, a % b};
      4'h8: return {1'b0, a & b};
      4'h9: return {1'b0, a | b};
      4'hA: return {1'b0, ~a};
      4'hB: return {1'b0, ~b};
      4'hC: return {1'b0, ~(a & b)};
      4'hD: return {1'b0, ~(a | b)};
      4'hE: return {1'b0, a ^ b};
      default: return {1'b0, ~(a ^ b)};
    endcase
  endfunction

  // Expected response word {result, carry, zero, div_zero}.
  function automatic logic [18:0] model_rsp(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] cr;
    if ((op == 4'h6 || op == 4'h7) && b == 16'h0000)
      return {16'hFFFF, 1'b0, 1'b0, 1'b1};
    cr = alu_ref(op, a, b);
    return {cr[15:0], cr[16], (cr[15:0] == 16'h0000), 1'b0};
  endfunction

  // Garbage while disabled exposes any sampling outside the settle window.
  logic [16:0] alu_bus;
  always_comb begin
    alu_bus = 17'h1DEAD;
    if (ALU_Enable_Out)
      alu_bus = alu_ref(ALU_Operation_Select_Out, ALU_Data_A_Out, ALU_Data_B_Out);
  end
  assign ALU_Result_In = alu_bus[15:0];
  assign ALU_Carry_In  = alu_bus[16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock_In);
    #1;
  endtask

  task automatic rand_cmd(output logic [3:0] op, output logic [15:0] a, output logic [15:0] b);
    op = 4'($urandom_range(0, 15));
    a  = 16'($urandom);
    b  = 16'($urandom);
    if ((op == 4'h6 || op == 4'h7) && b == 16'h0000) b = 16'h0001;
  endtask

  task automatic directed(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [18:0] exp, input int exp_lat,
                          input int exp_en);
    int lat = 0;
    int en  = 0;
    Rsp_Ready_In = 1'b1;
    Cmd_Valid_In = 1'b1;
    Cmd_Op_In = op; Cmd_A_In = a; Cmd_B_In = b;
    tick();
    Cmd_Valid_In = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ALU_Enable_Out) en++;
      if (Rsp_Valid_Out) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_enable_cycles"}, en, exp_en);
    chk({tag, "_rsp"}, {Rsp_Result_Out, Rsp_Carry_Out, Rsp_Zero_Out, Rsp_Div_Zero_Out}, exp);
    $display("directed %s op=%h a=%h b=%h result=%h lat=%0d", tag, op, a, b, Rsp_Result_Out, lat);
    tick();
    chk({tag, "_rsp_drop"}, Rsp_Valid_Out, 0);
  endtask

  task automatic producer(input int n);
    int   sent  = 0;
    int   guard = 0;
    logic rdy;
    logic [3:0] op;
    logic [15:0] a, b;
    while (sent < n && guard < 20000) begin
      if (!Cmd_Valid_In && $urandom_range(0, 2) != 0) begin
        rand_cmd(op, a, b);
        Cmd_Op_In = op; Cmd_A_In = a; Cmd_B_In = b;
        Cmd_Valid_In = 1'b1;
      end
      rdy = Cmd_Ready_Out;
      tick();
      guard++;
      if (Cmd_Valid_In && rdy) begin
        exp_q.push_back(model_rsp(Cmd_Op_In, Cmd_A_In, Cmd_B_In));
        sent++;
        Cmd_Valid_In = 1'b0;
      end
    end
    Cmd_Valid_In = 1'b0;
    if (sent < n) chk("cmd_timeout", sent, n);
  endtask

  task automatic consumer(input int n, input bit rand_ready);
    int got   = 0;
    int guard = 0;
    logic [18:0] exp;
    logic [18:0] obs;
    while (got < n && guard < 30000) begin
      Rsp_Ready_In = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (Rsp_Valid_Out && Rsp_Ready_In) begin
        obs = {Rsp_Result_Out, Rsp_Carry_Out, Rsp_Zero_Out, Rsp_Div_Zero_Out};
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          chk("rsp_match", obs, exp);
        end
        $display("rsp %0d result=%h carry=%b zero=%b dz=%b", got, Rsp_Result_Out,
                 Rsp_Carry_Out, Rsp_Zero_Out, Rsp_Div_Zero_Out);
        got++;
      end
      tick();
      guard++;
    end
    Rsp_Ready_In = 1'b0;
    if (got < n) chk("rsp_timeout", got, n);
  endtask

  initial begin
    int acc;
    int idx;
    int stale;
    int found;
    logic rdy;
    logic [3:0] op;
    logic [15:0] a, b;

    Reset_n_In = 1'b0;
    Cmd_Valid_In = 1'b0;
    Cmd_Op_In = '0; Cmd_A_In = '0; Cmd_B_In = '0;
    Rsp_Ready_In = 1'b0;
    tick(); tick();
    chk("reset_cmd_ready", Cmd_Ready_Out, 1);
    chk("reset_rsp_valid", Rsp_Valid_Out, 0);
    chk("reset_alu_en", ALU_Enable_Out, 0);
    chk("reset_count", Cmd_Count_Out, 0);
    chk("reset_busy", Busy_Out, 0);
    Reset_n_In = 1'b1;
    tick();

    directed("add", 4'h2, 16'h1234, 16'h0001, {16'h1235, 1'b0, 1'b0, 1'b0}, 3, 1);
    directed("inc_wrap", 4'h0, 16'hFFFF, 16'h0000, {16'h0000, 1'b1, 1'b1, 1'b0}, 3, 1);
    directed("div_zero", 4'h6, 16'h0042, 16'h0000, {16'hFFFF, 1'b0, 1'b0, 1'b1}, 2, 0);

    // Back-pressure: seven commands offered while responses are stalled.
    Rsp_Ready_In = 1'b0;
    acc = 0; idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 7) begin
        if (!Cmd_Valid_In) begin
          rand_cmd(op, a, b);
          Cmd_Op_In = op; Cmd_A_In = a; Cmd_B_In = b;
        end
        Cmd_Valid_In = 1'b1;
      end else begin
        Cmd_Valid_In = 1'b0;
      end
      rdy = Cmd_Ready_Out;
      tick();
      if (Cmd_Valid_In && rdy) begin
        exp_q.push_back(model_rsp(Cmd_Op_In, Cmd_A_In, Cmd_B_In));
        acc++; idx++;
        Cmd_Valid_In = 1'b0;
      end
    end
    Cmd_Valid_In = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_cmd_ready", Cmd_Ready_Out, 0);
    chk("bp_count", Cmd_Count_Out, 4);
    chk("bp_rsp_waiting", Rsp_Valid_Out, 1);
    consumer(5, 1'b0);
    chk("bp_queue_empty", exp_q.size(), 0);
    tick(); tick();

    // Reset while DRIVE is active with three commands queued.
    Rsp_Ready_In = 1'b0;
    for (int c = 0; c < 20 && Cmd_Count_Out != 3'd4; c++) begin
      rand_cmd(op, a, b);
      Cmd_Op_In = op; Cmd_A_In = a; Cmd_B_In = b;
      Cmd_Valid_In = 1'b1;
      tick();
    end
    Cmd_Valid_In = 1'b0;
    tick();
    Rsp_Ready_In = 1'b1;
    tick();
    Rsp_Ready_In = 1'b0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      if (ALU_Enable_Out) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("rst_reached_drive", found, 1);
    chk("rst_queued", Cmd_Count_Out, 3);
    #2 Reset_n_In = 1'b0;
    #1;
    chk("rst_rsp_valid", Rsp_Valid_Out, 0);
    chk("rst_alu_en", ALU_Enable_Out, 0);
    chk("rst_count", Cmd_Count_Out, 0);
    chk("rst_cmd_ready", Cmd_Ready_Out, 1);
    chk("rst_alu_a", ALU_Data_A_Out, 0);
    tick(); tick();
    Reset_n_In = 1'b1;
    Rsp_Ready_In = 1'b1;
    stale = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (Rsp_Valid_Out || ALU_Enable_Out) stale++;
    end
    chk("rst_no_stale", stale, 0);
    chk("rst_idle_busy", Busy_Out, 0);

    // Randomized traffic with independent command and response gaps.
    fork
      producer(200);
      consumer(200, 1'b1);
    join
    chk("rand_queue_empty", exp_q.size(), 0);
    tick(); tick();
    chk("final_busy", Busy_Out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_16_bit_sequencer.md
Name: alu_16_bit_sequencer

Overview:
Command sequencer that sits directly upstream of the 16-bit ALU and consumes its results. It buffers operation commands (op, A, B) in a small FIFO and issues them one at a time to the ALU. It holds the operands stable for a settle window, then captures result and carry. Each result is returned with status flags over a valid/ready response port, strictly in command order.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; must be a power of 2, minimum 2
SETTLE_CYCLES, 1, cycles the ALU is held enabled before capture; minimum 1

Ports:
Clock_In  input  1  single clock; all logic is rising-edge
Reset_n_In  input  1  reset, asynchronous assert, active-low
Cmd_Valid_In  input  1  command present
Cmd_Ready_Out  output  1  command FIFO not full
Cmd_Op_In  input  4  ALU opcode 0x0-0xF
Cmd_A_In  input  16  operand A
Cmd_B_In  input  16  operand B
Cmd_Count_Out  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
Busy_Out  output  1  FSM not IDLE, or FIFO non-empty
ALU_Enable_Out  output  1  drives ALU Enable_In
ALU_Operation_Select_Out  output  4  drives ALU opcode
ALU_Data_A_Out  output  16  drives ALU A
ALU_Data_B_Out  output  16  drives ALU B
ALU_Result_In  input  16  ALU Result_Out
ALU_Carry_In  input  1  ALU Carry_Out
Rsp_Valid_Out  output  1  response present
Rsp_Ready_In  input  1  response accepted
Rsp_Result_Out  output  16  captured result
Rsp_Carry_Out  output  1  captured carry
Rsp_Zero_Out  output  1  captured result == 0x0000
Rsp_Div_Zero_Out  output  1  op 0x6/0x7 with B == 0

Behaviour:
- Reset (asynchronous, Reset_n_In low):
  - FIFO emptied; FSM goes to IDLE.
  - All outputs 0 except Cmd_Ready_Out = 1.
  - Any in-flight command and any pending response are discarded. Rsp_Valid_Out drops immediately.
- Command push: on Cmd_Valid_In && Cmd_Ready_Out at a rising edge. Cmd_Ready_Out = (count != FIFO_DEPTH).
- Pop is driven by a registered not-empty flag. A push and a pop in the same cycle leave the count unchanged.
- FSM states: IDLE, LOAD, DRIVE, RESPOND.
  - IDLE: if FIFO non-empty, pop into operand registers, then go to LOAD.
  - LOAD: if op is 0x6 or 0x7 and B == 0, write the divide-by-zero response, then go to RESPOND. Otherwise go to DRIVE with the settle counter set to SETTLE_CYCLES-1.
  - DRIVE: ALU_Enable_Out = 1 and operands stable. On the final count, register ALU_Result_In, ALU_Carry_In and the zero flag, then go to RESPOND.
  - RESPOND: Rsp_Valid_Out = 1 and all Rsp_* fields are held stable until Rsp_Valid_Out && Rsp_Ready_In. On that handshake, pop and go to LOAD if the FIFO is non-empty, otherwise go to IDLE.
- Outside DRIVE:
  - ALU_Enable_Out = 0; ALU_Data/Op outputs hold their last values.
  - ALU_Result_In is never sampled, since the ALU drives Z while disabled.
- Latency, with accept at edge 0 and an idle sequencer:
  - Normal op: Rsp_Valid_Out high after edge 2+SETTLE_CYCLES (edge 3 at default).
  - Divide-by-zero: Rsp_Valid_Out high after edge 2.
- Back-to-back throughput: one response per 2+SETTLE_CYCLES cycles (LOAD, DRIVE×SETTLE, RESPOND), with Rsp_Ready_In held high.
- Divide-by-zero response: Rsp_Result_Out = 0xFFFF, Rsp_Carry_Out = 0, Rsp_Zero_Out = 0, Rsp_Div_Zero_Out = 1. ALU_Enable_Out never asserts for that command.
- Rsp_Div_Zero_Out = 0 for every other response.
- Arithmetic belongs to the ALU. The sequencer only forwards the op and captures the 17-bit {carry, result}.
- Ordering: responses leave in exactly command-accept order.

Decomposition:
- Package alu_16_bit_pkg:
  - DATA_WIDTH = 16, OP_WIDTH = 4.
  - Opcode enum: OP_INC=0x0, OP_DEC, OP_ADD, OP_SUB_AB, OP_SUB_BA, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_NOT_A, OP_NOT_B, OP_NAND, OP_NOR, OP_XOR, OP_XNOR=0xF.
  - Packed struct alu_cmd_t {op, a, b}.
  - FSM state enum.
  - DIV_ZERO_RESULT = 16'hFFFF.
- Sub-module alu_cmd_fifo:
  - Synchronous FIFO of alu_cmd_t, parameterised by depth.
  - Ports: push/pop, full/empty, count.
- The ALU itself is instantiated alongside the sequencer in the bench or top level, not inside it.

Test Plan:
- Single ADD: op 0x2, A=0x1234, B=0x0001, Rsp_Ready_In=1 -> Rsp_Result 0x1235, carry 0, zero 0, Rsp_Valid exactly 3 cycles after accept, ALU_Enable_Out high for exactly 1 cycle.
- Carry/zero: op 0x0 (A+1), A=0xFFFF -> result 0x0000, carry 1, zero 1.
- Divide-by-zero: op 0x6, A=0x0042, B=0x0000 -> result 0xFFFF, div_zero 1, ALU_Enable_Out never asserted, Rsp_Valid 2 cycles after accept.
- Back-pressure: Rsp_Ready_In=0, present 7 commands -> exactly 5 accepted (1 in flight + 4 in FIFO), Cmd_Ready_Out low, Cmd_Count_Out=4.
  - Then release Rsp_Ready_In -> 5 responses in push order, each matching a software ALU model.
- Reset mid-operation: assert Reset_n_In while in DRIVE with 3 queued -> Rsp_Valid_Out, ALU_Enable_Out, Cmd_Count_Out go 0 immediately, Cmd_Ready_Out 1.
  - After release, no stale response appears.
- Random: 200 commands with random valid/ready gaps, all 16 opcodes, nonzero B for ops 6/7 -> every response matches the model and ordering holds.
